jtag_master: RTL
================

# jtag_master

Host-side JTAG driver that generates TCK/TMS/TDI for the on-chip TAP (`tap_controller` plus the IR/DR scan chains) and captures TDO. It accepts one scan command at a time: TAP reset, IR scan or DR scan of 1..DATA_W bits. For each command it walks the TAP from Run-Test/Idle through the scan and back to Run-Test/Idle, then returns the captured TDO bits. It sits directly upstream of the TAP and lets an on-chip or bench host drive boundary/debug registers without bit-banging.

## Interface
- DATA_W, 32, maximum scan length and data width
- LEN_W, 5, width of cmdLen; DATA_W <= 2**LEN_W
- TCK_DIV, 2, clk cycles per TCK half-period; 0 behaves as 1
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; one clock, synchronous and active-high
- cmdValid  in  1  command request
- cmdReady  out  1  block idle, command accepted when cmdValid&&cmdReady
- cmdRst  in  1  1 = TAP reset command (cmdIr/cmdLen/cmdData ignored)
- cmdIr  in  1  1 = IR scan, 0 = DR scan
- cmdLen  in  LEN_W  scan length minus one (0 -> 1 bit)
- cmdData  in  DATA_W  TDI bits, LSB shifted first
- rspValid  out  1  one-cycle pulse, scan complete
- rspData  out  DATA_W  captured TDO, bit i = i-th shifted bit, bits above cmdLen are 0; held until next accept
- TCK  out  1  test clock, idles low
- TMS  out  1  test mode select
- TDI  out  1  test data to TAP
- TDO  in  1  test data from TAP

## Operation
- States: INIT, IDLE, HDR, SHIFT, TRL, DONE.
- INIT is entered on rst. It issues 6 TCK cycles with TMS 1,1,1,1,1,0 (Test-Logic-Reset, then Run-Test/Idle) and then goes to IDLE. cmdReady=0 throughout INIT.
- IDLE: cmdReady=1. On accept, latch the command into shift/length registers, drop cmdReady and go to HDR. A cmdRst command re-enters INIT; on completion it pulses rspValid with rspData=0.
- HDR drives the TMS header with TDI=0:
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR scan: 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- SHIFT runs cmdLen+1 TCK cycles:
  - TDI = shift register bit 0.
  - TMS=0, except TMS=1 on the last bit (enters Exit1).
  - TDO sampled each rising edge into rspData at index bit-count.
- TRL drives TMS 1,0 (Update, Run-Test/Idle) with TDI=0. Then DONE: pulse rspValid for one clk and return to IDLE.
- TCK cycle counts:
  - DR scan: N+5.
  - IR scan: N+6.
  - Reset: 6.
  - N = cmdLen+1.
- cmdValid while cmdReady=0 is ignored; no queuing.

## Timing
- Reset values: TCK=0, TMS=1, TDI=0, cmdReady=0, rspValid=0, rspData=0, state=INIT.
- TCK cycle is a low phase of TCK_DIV clk followed by a high phase of TCK_DIV clk.
- TMS/TDI change only in the clk cycle where TCK falls (start of the low phase). They are stable for the whole TCK period.
- TDO is sampled in the clk cycle where TCK rises.
- The first TCK low phase starts the clk cycle after accept.
- rspValid and cmdReady assert in the clk cycle where TCK falls after the last high phase.
- Command latency, accept to rspValid, is 1 + T*2*TCK_DIV clk, where T is the TCK cycle count.
- rst asserted mid-scan:
  - Outputs return to reset values on the next edge: TCK low, any partial scan abandoned, no rspValid.
  - The INIT sequence reruns.
- cmdLen = DATA_W-1 shifts every bit. The bit counter must not wrap: it is LEN_W+1 bits wide, or compares against cmdLen explicitly.

## Structure
- Shared header `jtag_defs.vh` holds the state encodings, the header/trailer TMS patterns and lengths (DR 3'b001/3, IR 4'b0011/4 LSB-first, TRL 2'b01/2, INIT 6'b011111/6), and TAP state numbers shared with `tap_controller`.
- Sub-module `jtag_tck_gen` contains the half-period counter. It has an enable input and outputs TCK plus the tckFall/tckRise single-clk strobes. jtag_master sequences off those strobes only.

## Test plan
- rst 1 cycle, TCK_DIV=2 -> 6 TCK pulses, TMS 1,1,1,1,1,0. cmdReady rises 1+6*4=25 clk after rst release. All outputs are at reset values during rst.
- IR scan cmdLen=7, cmdData=8'h02, TAP model -> TMS 1,1,0,0,0,0,0,0,0,0,0,1,1,0 (14 TCK). TDI during shift is 0,1,0,0,0,0,0,0. rspData=8'h01 (IR capture pattern xxxxxx01). rspValid pulses exactly once.
- DR scan cmdLen=31 to the ID register -> 37 TCK, rspData=32'h12345678.
- 1-bit DR scan cmdLen=0, cmdData=1 -> TMS 1,0,0,1,1,0. TDI=1 only in the shift cycle. rspData[31:1]=0.
- cmdValid held high through a scan -> second command accepted only in the rspValid cycle. rst pulsed at shift bit 10 -> TCK low next clk, no rspValid, INIT sequence repeats.
- cmdRst command from IDLE -> 6 TCK with TMS 1,1,1,1,1,0, then rspValid with rspData=0. Repeat at TCK_DIV=0 to confirm it behaves as TCK_DIV=1.

Source files
------------

// File: rtl/jtag_master_pkg.sv
// ----------------------------------------------------------------------------
// jtag_master_pkg : shared state encodings and TMS header/trailer patterns
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jtag_master_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_HDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_TRL   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // IEEE 1149.1 TAP state numbers, common to tap_controller
  typedef enum logic [3:0] {
    TAP_EXIT2_DR  = 4'h0, TAP_EXIT1_DR  = 4'h1, TAP_SHIFT_DR  = 4'h2, TAP_PAUSE_DR  = 4'h3,
    TAP_SEL_IR    = 4'h4, TAP_UPDATE_DR = 4'h5, TAP_CAPT_DR   = 4'h6, TAP_SEL_DR    = 4'h7,
    TAP_EXIT2_IR  = 4'h8, TAP_EXIT1_IR  = 4'h9, TAP_SHIFT_IR  = 4'hA, TAP_PAUSE_IR  = 4'hB,
    TAP_RTI       = 4'hC, TAP_UPDATE_IR = 4'hD, TAP_CAPT_IR   = 4'hE, TAP_TLR       = 4'hF
  } tap_state_t;

  localparam int PAT_W = 6;

  // TMS sequences, LSB issued first
  localparam logic [PAT_W-1:0] TMS_INIT = 6'b011111;
  localparam int               INIT_LEN = 6;
  localparam logic [PAT_W-1:0] TMS_DR   = 6'b000001;
  localparam int               DR_LEN   = 3;
  localparam logic [PAT_W-1:0] TMS_IR   = 6'b000011;
  localparam int               IR_LEN   = 4;
  localparam logic [PAT_W-1:0] TMS_TRL  = 6'b000001;
  localparam int               TRL_LEN  = 2;

  function automatic int div_eff(input int d);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tck_gen.sv
// ----------------------------------------------------------------------------
// jtag_tck_gen : TCK half-period divider with rise/fall strobes
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtag_tck_gen
  import jtag_master_pkg::*;
#(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int DIV = div_eff(TCK_DIV);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          last;

  // Strobes flag the clk edge on which TCK is about to toggle
  assign last     = (cnt_q == CW'(DIV - 1));
  assign tck_rise = en && last && !tck_q;
  assign tck_fall = en && last && tck_q;
  assign tck      = tck_q;

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtag_master.sv
// ----------------------------------------------------------------------------
// jtag_master : host-side JTAG driver issuing TAP reset / IR / DR scans
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 5,
  parameter int TCK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdRst,
  input  logic              cmdIr,
  input  logic [LEN_W-1:0]  cmdLen,
  input  logic [DATA_W-1:0] cmdData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  // One extra bit so the counter never wraps at cmdLen = DATA_W-1
  localparam int CNT_W = (LEN_W + 1 > 3) ? LEN_W + 1 : 3;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                ir_q, ir_d;
  logic                rst_cmd_q, rst_cmd_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                tck_en, tck_rise, tck_fall, accept;

  assign tck_en = (state_q == S_INIT) || (state_q == S_HDR) ||
                  (state_q == S_SHIFT) || (state_q == S_TRL);
  assign accept = cmdValid && ready_q;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (tck_en),
    .tck      (TCK),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pat_d       = pat_q;
    shift_d     = shift_q;
    rsp_data_d  = rsp_data_q;
    len_d       = len_q;
    ir_d        = ir_q;
    rst_cmd_d   = rst_cmd_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      S_INIT: if (tck_fall) begin
        if (idx_q == CNT_W'(INIT_LEN - 1)) begin
          state_d     = rst_cmd_q ? S_DONE : S_IDLE;
          rsp_valid_d = rst_cmd_q;
          rst_cmd_d   = 1'b0;
          ready_d     = 1'b1;
          tms_d       = 1'b0;
        end else begin
          idx_d = idx_q + CNT_W'(1);
          tms_d = pat_q[0];
          pat_d = pat_q >> 1;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          ready_d    = 1'b0;
          idx_d      = '0;
          tms_d      = 1'b1;
          tdi_d      = 1'b0;
          rsp_data_d = '0;
          if (cmdRst) begin
            state_d   = S_INIT;
            rst_cmd_d = 1'b1;
            pat_d     = TMS_INIT >> 1;
          end else begin
            state_d = S_HDR;
            ir_d    = cmdIr;
            len_d   = cmdLen;
            shift_d = cmdData;
            pat_d   = (cmdIr ? TMS_IR : TMS_DR) >> 1;
          end
        end
      end
      S_HDR: if (tck_fall) begin
        if (idx_q == (ir_q ? CNT_W'(IR_LEN - 1) : CNT_W'(DR_LEN - 1))) begin
          state_d = S_SHIFT;
          idx_d   = '0;
          tms_d   = (len_q == '0);
          tdi_d   = shift_q[0];
        end else begin
          idx_d = idx_q + CNT_W'(1);
          tms_d = pat_q[0];
          pat_d = pat_q >> 1;
        end
      end
      S_SHIFT: begin
        if (tck_rise) begin
          rsp_data_d = rsp_data_q | (DATA_W'(TDO) << idx_q);
        end
        if (tck_fall) begin
          shift_d = shift_q >> 1;
          if (idx_q == CNT_W'(len_q)) begin
            state_d = S_TRL;
            idx_d   = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
            pat_d   = TMS_TRL >> 1;
          end else begin
            idx_d = idx_q + CNT_W'(1);
            tdi_d = shift_d[0];
            tms_d = ((idx_q + CNT_W'(1)) == CNT_W'(len_q));
          end
        end
      end
      S_TRL: if (tck_fall) begin
        if (idx_q == CNT_W'(TRL_LEN - 1)) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          ready_d     = 1'b1;
          tms_d       = 1'b0;
        end else begin
          idx_d = idx_q + CNT_W'(1);
          tms_d = pat_q[0];
          pat_d = pat_q >> 1;
        end
      end
      default: begin
        state_d = S_INIT;
        idx_d   = '0;
        pat_d   = TMS_INIT >> 1;
        tms_d   = 1'b1;
        tdi_d   = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      pat_q       <= TMS_INIT >> 1;
      shift_q     <= '0;
      rsp_data_q  <= '0;
      len_q       <= '0;
      ir_q        <= 1'b0;
      rst_cmd_q   <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pat_q       <= pat_d;
      shift_q     <= shift_d;
      rsp_data_q  <= rsp_data_d;
      len_q       <= len_d;
      ir_q        <= ir_d;
      rst_cmd_q   <= rst_cmd_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmdReady = ready_q;
  assign rspValid = rsp_valid_q;
  assign rspData  = rsp_data_q;
  assign TMS      = tms_q;
  assign TDI      = tdi_q;

endmodule

`default_nettype wire
